// File: rtl/srd_rst_pkg.sv
// Shared types and counter-width helpers for the SerDes reset sequencer.
package srd_rst_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACK = 3'd1,
        WAIT_REL = 3'd2,
        SETTLE   = 3'd3,
        DONE     = 3'd4,
        RETRY    = 3'd5,
        ERR      = 3'd6
    } srd_rst_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int sat_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int tmo_cnt_w(input int timeout_cyc);
        return sat_cnt_w(timeout_cyc);
    endfunction

    function automatic int retry_cnt_w(input int max_retry);
        return sat_cnt_w(max_retry);
    endfunction

endpackage

// File: rtl/srd_rst_seq_ch.sv
// One SerDes channel reset sequencer: FSM, timeout/retry counters and request edge detect.
module srd_rst_seq_ch
    import srd_rst_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_rst_req_n,
    input  logic i_rst_ack_n,
    output logic o_rst_n,
    output logic o_rst_done,
    output logic o_err
);

    localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYC);
    localparam int RTY_W = retry_cnt_w(MAX_RETRY);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYC);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    srd_rst_state_e   state_r, state_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [RTY_W-1:0] retry_cnt_r, retry_cnt_s;
    logic             req_dly_r;
    logic             req_edge_s;
    logic             tmo_hit_s;
    logic             rst_n_s, done_s, err_s;

    assign req_edge_s = ~i_rst_req_n & req_dly_r;
    assign tmo_hit_s  = (tmo_cnt_r >= TMO_LAST);

    // Next-state and retry bookkeeping; ack wins over a timeout landing on the same cycle.
    always_comb begin
        state_s     = state_r;
        retry_cnt_s = retry_cnt_r;
        case (state_r)
            IDLE: begin
                if (i_start) state_s = WAIT_ACK;
                else         state_s = IDLE;
            end
            WAIT_ACK: begin
                if (!i_rst_ack_n)   state_s = WAIT_REL;
                else if (tmo_hit_s) state_s = RETRY;
                else                state_s = WAIT_ACK;
            end
            WAIT_REL: begin
                if (i_rst_ack_n)    state_s = SETTLE;
                else if (tmo_hit_s) state_s = RETRY;
                else                state_s = WAIT_REL;
            end
            SETTLE: state_s = DONE;
            DONE, ERR: begin
                if (req_edge_s) begin
                    state_s     = WAIT_ACK;
                    retry_cnt_s = '0;
                end else begin
                    state_s     = state_r;
                end
            end
            RETRY: begin
                if (retry_cnt_r < RTY_MAX) begin
                    state_s     = WAIT_ACK;
                    retry_cnt_s = retry_cnt_r + RTY_W'(1);
                end else begin
                    state_s     = ERR;
                end
            end
            default: begin
                state_s     = IDLE;
                retry_cnt_s = '0;
            end
        endcase
    end

    // Attempt timer restarts on every state change and saturates so it cannot wrap.
    always_comb begin
        tmo_cnt_s = tmo_cnt_r;
        if (state_s != state_r)      tmo_cnt_s = '0;
        else if (tmo_cnt_r != TMO_SAT) tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
        else                         tmo_cnt_s = tmo_cnt_r;
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        rst_n_s = 1'b1;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_s)
            WAIT_ACK: rst_n_s = 1'b0;
            DONE:     done_s  = 1'b1;
            ERR:      err_s   = 1'b1;
            default:  rst_n_s = 1'b1;
        endcase
    end

    // State, counters, request history and outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            tmo_cnt_r   <= '0;
            retry_cnt_r <= '0;
            req_dly_r   <= 1'b1;
            o_rst_n     <= 1'b1;
            o_rst_done  <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_r     <= state_s;
            tmo_cnt_r   <= tmo_cnt_s;
            retry_cnt_r <= retry_cnt_s;
            req_dly_r   <= i_rst_req_n;
            o_rst_n     <= rst_n_s;
            o_rst_done  <= done_s;
            o_err       <= err_s;
        end
    end

endmodule

// File: rtl/srd_rst_seq_mc.sv
// Multi-channel SerDes reset sequencer with ack timeout and retry.
// Optional power-up start staggering is enabled by defining SRD_RST_SEQ_STAGGER_EN.
module srd_rst_seq_mc
    import srd_rst_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_RETRY   = 3,
    parameter int STAGGER_CYC = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_rst_req_n,
    output logic [NUM_CH-1:0] o_rst_n,
    input  logic [NUM_CH-1:0] i_rst_ack_n,
    output logic [NUM_CH-1:0] o_rst_done,
    output logic [NUM_CH-1:0] o_err,
    output logic              o_all_done
);

    logic [NUM_CH-1:0] start_s;

    if (NUM_CH < 1 || NUM_CH > 32 || TIMEOUT_CYC < 1 || MAX_RETRY < 0 || STAGGER_CYC < 0)
    begin : g_bad_cfg
        $error("srd_rst_seq_mc: illegal parameter set");
    end

`ifdef SRD_RST_SEQ_STAGGER_EN
    localparam int STG_MAX = (NUM_CH - 1) * STAGGER_CYC;
    localparam int STG_W   = sat_cnt_w(STG_MAX);

    logic [STG_W-1:0] stg_cnt_r;

    // Shared power-up stagger counter, parked once the last channel has been released.
    always_ff @(posedge i_clk) begin
        if (i_rst)                           stg_cnt_r <= '0;
        else if (stg_cnt_r != STG_W'(STG_MAX)) stg_cnt_r <= stg_cnt_r + STG_W'(1);
        else                                 stg_cnt_r <= stg_cnt_r;
    end

    // Channel k first sees its start when the counter reaches k*STAGGER_CYC; the >= keeps
    // the grant asserted afterwards so a channel knocked back to IDLE can still recover.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_start
        localparam logic [STG_W-1:0] START_AT = STG_W'(k * STAGGER_CYC);
        assign start_s[k] = (stg_cnt_r >= START_AT);
    end
`else
    assign start_s = {NUM_CH{1'b1}};
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        srd_rst_seq_ch #(
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .MAX_RETRY   (MAX_RETRY)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_start     (start_s[c]),
            .i_rst_req_n (i_rst_req_n[c]),
            .i_rst_ack_n (i_rst_ack_n[c]),
            .o_rst_n     (o_rst_n[c]),
            .o_rst_done  (o_rst_done[c]),
            .o_err       (o_err[c])
        );
    end

    // Aggregate completion, one cycle behind the per-channel done flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_all_done <= 1'b0;
        else       o_all_done <= &o_rst_done;
    end

endmodule

// File: tb/tb_srd_rst_seq_mc.sv
// Directed bench for srd_rst_seq_mc (NUM_CH=2, TIMEOUT_CYC=16, MAX_RETRY=2, STAGGER_CYC=8).
module tb_srd_rst_seq_mc;

    localparam int NUM_CH = 2;

    logic              i_clk;
    logic              i_rst;
    logic [NUM_CH-1:0] i_rst_req_n;
    logic [NUM_CH-1:0] o_rst_n;
    logic [NUM_CH-1:0] i_rst_ack_n;
    logic [NUM_CH-1:0] o_rst_done;
    logic [NUM_CH-1:0] o_err;
    logic              o_all_done;

    int n_cmp;
    int n_bad;

    srd_rst_seq_mc #(
        .NUM_CH      (NUM_CH),
        .TIMEOUT_CYC (16),
        .MAX_RETRY   (2),
        .STAGGER_CYC (8)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rst_req_n (i_rst_req_n),
        .o_rst_n     (o_rst_n),
        .i_rst_ack_n (i_rst_ack_n),
        .o_rst_done  (o_rst_done),
        .o_err       (o_err),
        .o_all_done  (o_all_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       rst;
        logic [1:0] ack_n;
        logic [1:0] rst_n;
        logic [1:0] done;
        logic [1:0] err;
        logic       all;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] rst_n, input logic [1:0] done,
                           input logic [1:0] err, input logic all);
        chk({tag, "_rst_n"}, 32'(o_rst_n), 32'(rst_n));
        chk({tag, "_done"}, 32'(o_rst_done), 32'(done));
        chk({tag, "_err"}, 32'(o_err), 32'(err));
        chk({tag, "_all"}, 32'(o_all_done), 32'(all));
    endtask

    // ch0 never acks: three 16-cycle attempts with 1-cycle high gaps, then ERR.
    // Cycle t=0 is the cycle in which ch0 is kicked into its first attempt.
    task automatic ch0_fail_run(input bit with_ch1_ack, input bit poke_req);
        for (int t = 0; t < 52; t++) begin
            int  n;
            logic exp_rst_n0;
            i_rst_ack_n[1] = (with_ch1_ack && t >= 3 && t <= 7) ? 1'b0 : 1'b1;
            i_rst_ack_n[0] = 1'b1;
            if (poke_req) i_rst_req_n[0] = (t == 5 || t == 16) ? 1'b1 : 1'b0;
            else          i_rst_req_n[0] = 1'b1;
            step();
            n = t + 1;
            exp_rst_n0 = (n == 17 || n == 34 || n >= 51) ? 1'b1 : 1'b0;
            chk("retry_rst_n0", 32'(o_rst_n[0]), 32'(exp_rst_n0));
            chk("retry_err0", 32'(o_err[0]), (n >= 52) ? 32'd1 : 32'd0);
        end
        chk("retry_done0", 32'(o_rst_done[0]), 32'd0);
        chk("retry_done1", 32'(o_rst_done[1]), 32'd1);
        chk("retry_all", 32'(o_all_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

    initial begin
        int fall0;
        int fall1;
        n_cmp = 0;
        n_bad = 0;
        i_rst = 1'b1;
        i_rst_req_n = 2'b11;
        i_rst_ack_n = 2'b11;

        // rst, ack_n | expected rst_n, done, err, all_done (outputs after the edge)
        vecs[0]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0};
        vecs[11] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0};
        vecs[12] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1};
        vecs[13] = '{1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1};

        // Power-up sequence with both channels acking normally.
        for (int i = 0; i < 14; i++) begin
            i_rst       = vecs[i].rst;
            i_rst_ack_n = vecs[i].ack_n;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].done, vecs[i].err, vecs[i].all);
        end

        // ch1 re-sequence request from DONE; ch0 must stay put.
        i_rst_req_n = 2'b01;
        step();
        chk_all("req1_edge", 2'b01, 2'b01, 2'b00, 1'b1);
        i_rst_ack_n = 2'b01;
        step();
        chk_all("req1_ack", 2'b11, 2'b01, 2'b00, 1'b0);
        i_rst_ack_n = 2'b11;
        step();
        chk_all("req1_settle", 2'b11, 2'b01, 2'b00, 1'b0);
        step();
        chk_all("req1_done", 2'b11, 2'b11, 2'b00, 1'b0);
        step();
        chk_all("req1_all", 2'b11, 2'b11, 2'b00, 1'b1);
        i_rst_req_n = 2'b11;

        // ch0 never acks after reset; ch1 completes normally.
        i_rst = 1'b1;
        step();
        chk_all("rst2", 2'b11, 2'b00, 2'b00, 1'b0);
        i_rst = 1'b0;
        ch0_fail_run(1'b1, 1'b0);

        // From ERR: a request edge restarts; edges in WAIT_ACK/RETRY are ignored.
        ch0_fail_run(1'b0, 1'b1);

        // Reset from ERR/DONE clears the flags.
        i_rst = 1'b1;
        i_rst_req_n = 2'b11;
        i_rst_ack_n = 2'b11;
        step();
        chk_all("rst_from_err", 2'b11, 2'b00, 2'b00, 1'b0);

        // Reset while both channels are in WAIT_REL, then auto-restart.
        i_rst = 1'b0;
        step();
        chk("wr_start", 32'(o_rst_n), 32'd0);
        i_rst_ack_n = 2'b00;
        step();
        chk("wr_ack", 32'(o_rst_n), 32'd3);
        step();
        i_rst = 1'b1;
        step();
        chk_all("wr_rst", 2'b11, 2'b00, 2'b00, 1'b0);
        i_rst = 1'b0;
        i_rst_ack_n = 2'b11;
        step();
        chk_all("wr_restart", 2'b00, 2'b00, 2'b00, 1'b0);
        i_rst_ack_n = 2'b00;
        step();
        chk("wr_ack2", 32'(o_rst_n), 32'd3);
        i_rst_ack_n = 2'b11;
        step();
        chk("wr_settle", 32'(o_rst_done), 32'd0);
        step();
        chk("wr_done", 32'(o_rst_done), 32'd3);

        // Start spacing between channels after reset release.
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_rst_ack_n = 2'b11;
        fall0 = -1;
        fall1 = -1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (fall0 < 0 && o_rst_n[0] == 1'b0) fall0 = c;
            if (fall1 < 0 && o_rst_n[1] == 1'b0) fall1 = c;
        end
        chk("stg_fall0", 32'(fall0), 32'd1);
`ifdef SRD_RST_SEQ_STAGGER_EN
        chk("stg_gap", 32'(fall1 - fall0), 32'd8);
`else
        chk("stg_gap", 32'(fall1 - fall0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
